// File: rtl/imem_pipe.sv
// imem_pipe: pipelined byte-addressed instruction memory for the Ludi-V fetch path.
// Returns little-endian 32-bit words through a valid/ready request/response
// handshake with LATENCY register stages, supports flush on branch redirect,
// reports misaligned/out-of-range faults and has a byte-wide loader port.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready/req_addr   fetch request handshake and byte address
//   flush                      drop all in-flight requests
//   rsp_valid/rsp_ready        response handshake
//   rsp_instr/rsp_addr/rsp_err response word, echoed address, fault flag
//   ld_we/ld_addr/ld_data      loader byte write port
module imem_pipe #(
   parameter int    DEPTH_BYTES = 1024,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = "src/hello_world.hex"
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   input  logic                           flush,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_instr,
   output logic [31:0]                    rsp_addr,
   output logic                           rsp_err,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_BYTES)-1:0] ld_addr,
   input  logic [7:0]                     ld_data
);

   localparam int AW = $clog2(DEPTH_BYTES);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_pipe: LATENCY must be 1..4");
   end

   logic [7:0] mem [0:DEPTH_BYTES-1];

   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
   end

   // Read happens at acceptance against the pre-edge memory contents, so a
   // loader write in the same cycle is not visible (read-before-write).
   logic [AW-1:0] rd_idx;
   logic          rd_err;
   logic [31:0]   rd_instr;

   always_comb begin
      rd_err   = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH_BYTES));
      rd_idx   = req_addr[AW-1:0];
      rd_instr = '0;
      // Faulting addresses never index the array.
      if (!rd_err) begin
         rd_instr = {mem[{rd_idx[AW-1:2], 2'd3}], mem[{rd_idx[AW-1:2], 2'd2}],
                     mem[{rd_idx[AW-1:2], 2'd1}], mem[{rd_idx[AW-1:2], 2'd0}]};
      end
   end

   logic [LATENCY-1:0] st_valid;
   logic [LATENCY-1:0] st_err;
   logic [31:0]        st_addr  [LATENCY];
   logic [31:0]        st_instr [LATENCY];
   logic               adv;
   logic               load;

   assign adv       = !st_valid[LATENCY-1] || rsp_ready;
   // A flush empties the whole pipe, so stage 1 may accept even while stalled.
   assign load      = adv || flush;
   assign req_ready = load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         st_err   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            st_addr[i]  <= '0;
            st_instr[i] <= '0;
         end
      end else begin
         if (load) begin
            st_valid[0] <= req_valid;
            st_addr[0]  <= req_addr;
            st_instr[0] <= rd_instr;
            st_err[0]   <= rd_err;
         end
         for (int i = 1; i < LATENCY; i++) begin
            if (adv) begin
               st_valid[i] <= st_valid[i-1];
               st_addr[i]  <= st_addr[i-1];
               st_instr[i] <= st_instr[i-1];
               st_err[i]   <= st_err[i-1];
            end
            if (flush) st_valid[i] <= 1'b0;
         end
      end
   end

   assign rsp_valid = st_valid[LATENCY-1];
   assign rsp_addr  = st_addr[LATENCY-1];
   assign rsp_instr = st_instr[LATENCY-1];
   assign rsp_err   = st_err[LATENCY-1];

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: self-checking bench for imem_pipe. Main instance uses
// LATENCY=3; a LATENCY=1 instance shares the inputs for the single-cycle case.
// Expected responses come from a bench-side byte image and a scoreboard queue.
module tb_imem_pipe;
   localparam int LAT   = 3;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        flush = 1'b0;
   logic        rsp_ready = 1'b1;
   logic        ld_we = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [7:0]  ld_data = '0;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_instr, rsp_addr;
   logic        u1_req_ready, u1_rsp_valid, u1_rsp_err;
   logic [31:0] u1_rsp_instr, u1_rsp_addr;

   imem_pipe #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

   imem_pipe #(.DEPTH_BYTES(DEPTH), .LATENCY(1), .INIT_FILE("")) dut_l1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(u1_req_ready),
      .req_addr(req_addr), .flush(flush), .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(u1_rsp_instr), .rsp_addr(u1_rsp_addr), .rsp_err(u1_rsp_err),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
   } rsp_t;

   rsp_t       sb[$];
   rsp_t       sb_e;
   logic [7:0] img [0:DEPTH-1];
   int         tests = 0;
   int         fails = 0;

   function automatic rsp_t exp_rsp(input logic [31:0] a);
      rsp_t r;
      int   i;
      r.addr  = a;
      r.err   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH));
      r.instr = '0;
      if (!r.err) begin
         i = int'(a);
         r.instr = {img[i+3], img[i+2], img[i+1], img[i]};
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a);
      req_valid = 1'b1;
      req_addr  = a;
      sb.push_back(exp_rsp(a));
   endtask

   task automatic load_byte(input int a, input logic [7:0] d);
      ld_we   = 1'b1;
      ld_addr = 10'(a);
      ld_data = d;
      tick();
      ld_we  = 1'b0;
      img[a] = d;
   endtask

   task automatic load_word(input int a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) load_byte(a + b, w[8*b +: 8]);
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Scoreboard: every response handshake pops and compares the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got addr=%h instr=%h err=%b, required no response",
                     rsp_addr, rsp_instr, rsp_err);
         end else begin
            sb_e = sb.pop_front();
            if ({rsp_addr, rsp_instr, rsp_err} !== sb_e) begin
               fails++;
               $display("FAIL sb_rsp: got addr=%h instr=%h err=%b, required addr=%h instr=%h err=%b",
                        rsp_addr, rsp_instr, rsp_err, sb_e.addr, sb_e.instr, sb_e.err);
            end
         end
      end
   end

   task automatic test_reset();
      #2;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", rsp_valid); end
      tests++; if (rsp_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h required 0", rsp_instr); end
      tests++; if (rsp_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h required 0", rsp_addr); end
      tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", rsp_err); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load_image();
      load_word(32'h0, 32'h0000_0513);
      for (int w = 1; w < 8; w++) load_word(4 * w, 32'h1000_0000 + w * 32'h0102_0304);
      load_word(32'h3FC, 32'hCAFE_F00D);
   endtask

   task automatic test_basic();
      bit ok;
      issue(32'h0);
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b required 1", req_ready); end
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= LAT + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            tests++;
            if ({u1_rsp_valid, u1_rsp_instr, u1_rsp_err, u1_rsp_addr} !== {1'b1, 32'h0000_0513, 1'b0, 32'h0}) begin
               fails++;
               $display("FAIL basic_l1: got v=%b instr=%h err=%b addr=%h, required v=1 instr=00000513 err=0 addr=0",
                        u1_rsp_valid, u1_rsp_instr, u1_rsp_err, u1_rsp_addr);
            end
         end
         if (c == 2) begin
            tests++; if (u1_rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_l1_once: got %b required 0", u1_rsp_valid); end
         end
         tests++;
         if (rsp_valid !== (c == LAT)) begin
            fails++;
            $display("FAIL basic_latency: cycle %0d got valid=%b required %b", c, rsp_valid, (c == LAT));
         end
         tick();
      end
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int c = 0; c <= LAT + 4; c++) begin
         if (c < 4) issue(32'(4 * c));
         else req_valid = 1'b0;
         @(negedge clk);
         tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: cycle %0d got %b required 1", c, req_ready); end
         tests++;
         if (rsp_valid !== (c >= LAT && c < LAT + 4)) begin
            fails++;
            $display("FAIL b2b_valid: cycle %0d got %b required %b", c, rsp_valid, (c >= LAT && c < LAT + 4));
         end
         tick();
      end
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL b2b_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   task automatic test_stall();
      bit          ok;
      logic [31:0] held;
      held = exp_rsp(32'h10).instr;
      for (int c = 0; c <= LAT + 8; c++) begin
         if (c < 3) issue(32'h10 + 32'(4 * c));
         else req_valid = 1'b0;
         rsp_ready = !(c >= LAT && c < LAT + 5);
         @(negedge clk);
         if (c >= LAT && c < LAT + 5) begin
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: cycle %0d got %b required 0", c, req_ready); end
            tests++;
            if ({rsp_addr, rsp_instr} !== {32'h10, held}) begin
               fails++;
               $display("FAIL stall_hold: cycle %0d got addr=%h instr=%h required addr=00000010 instr=%h", c, rsp_addr, rsp_instr, held);
            end
         end
         tests++;
         if (rsp_valid !== (c >= LAT && c < LAT + 8)) begin
            fails++;
            $display("FAIL stall_valid: cycle %0d got %b required %b", c, rsp_valid, (c >= LAT && c < LAT + 8));
         end
         tick();
      end
      rsp_ready = 1'b1;
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL stall_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   task automatic test_fault();
      bit ok;
      issue(32'h2);          tick();
      issue(32'h400);        tick();
      issue(32'hFFFF_FFFC);  tick();
      issue(32'h3FC);        tick();
      issue(32'h3FF);        tick();
      req_valid = 1'b0;
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL fault_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   task automatic test_flush();
      bit ok;
      for (int c = 0; c <= LAT + 5; c++) begin
         if (c < 3) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * c);
         end else if (c == 3) begin
            rsp_ready = 1'b0;
            flush     = 1'b1;
            issue(32'h10);
         end else begin
            flush     = 1'b0;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
         end
         @(negedge clk);
         if (c == 3) begin
            tests++;
            if ({req_ready, rsp_valid} !== 2'b11) begin
               fails++;
               $display("FAIL flush_ready: got ready=%b valid=%b required ready=1 valid=1", req_ready, rsp_valid);
            end
         end else if (c > 3) begin
            tests++;
            if (rsp_valid !== (c == 3 + LAT)) begin
               fails++;
               $display("FAIL flush_valid: cycle %0d got %b required %b", c, rsp_valid, (c == 3 + LAT));
            end
         end
         tick();
      end
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL flush_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   task automatic test_loader_reset();
      bit ok;
      load_byte(32'h20, 8'hEF);
      load_byte(32'h21, 8'hBE);
      load_byte(32'h22, 8'hAD);
      load_byte(32'h23, 8'hDE);
      issue(32'h20);
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
         @(negedge clk);
         if (c == LAT) begin
            tests++;
            if ({rsp_valid, rsp_instr} !== {1'b1, 32'hDEAD_BEEF}) begin
               fails++;
               $display("FAIL loader_word: got v=%b instr=%h required v=1 instr=deadbeef", rsp_valid, rsp_instr);
            end
         end
         tick();
      end
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL loader_drain: %0d responses outstanding, required 0", sb.size()); end

      // Reset while responses are in flight.
      issue(32'h20); tick();
      issue(32'h24); tick();
      req_valid = 1'b0; tick();
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre: got valid=%b required 1", rsp_valid); end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({rsp_valid, req_ready, rsp_instr, rsp_err} !== {1'b1 ^ 1'b1, 1'b1, 32'h0, 1'b0}) begin
         fails++;
         $display("FAIL midrst_out: got valid=%b ready=%b instr=%h err=%b required valid=0 ready=1 instr=0 err=0",
                  rsp_valid, req_ready, rsp_instr, rsp_err);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      issue(32'h20); tick();
      req_valid = 1'b0;
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL midrst_drain: %0d responses outstanding, required 0", sb.size()); end

      // Read and loader write to the same byte in one cycle: old byte returned.
      issue(32'h20);
      ld_we   = 1'b1;
      ld_addr = 10'h20;
      ld_data = 8'h11;
      tick();
      ld_we     = 1'b0;
      img[32'h20] = 8'h11;
      issue(32'h20);
      tick();
      req_valid = 1'b0;
      drain(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rbw_drain: %0d responses outstanding, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      load_image();
      test_basic();
      test_back_to_back();
      test_stall();
      test_fault();
      test_flush();
      test_loader_reset();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL final_empty: %0d responses outstanding, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
